alu_issue_stage: RTL

//  Producer side of the ALU operand/opcode interface: decodes a MIPS instruction, selects the
//  ALU operands, encodes the 4-bit ALUOp, and presents them through a registered ID/EX stage.
//  The stage uses valid/ready handshakes and a 2-entry skid buffer, so in_ready is a flop.

---
 rtl/alu_issue_stage.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - MIPS decode, ALU operand select and 2-entry skid ID/EX stage
module alu_issue_stage #(
  parameter int WIDTH = 32,
  parameter int RA_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [WIDTH-1:0] in_rs_data,
  input  logic [WIDTH-1:0] in_rt_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [3:0]       out_aluop,
  output logic [RA_W-1:0]  out_dest,
  output logic             out_we,
  output logic             out_illegal
);

  localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_AND = 4'b0010,
                         OP_OR  = 4'b0011, OP_XOR = 4'b0100, OP_SLL = 4'b0101,
                         OP_SRL = 4'b0110, OP_NOR = 4'b0111, OP_LT  = 4'b1000,
                         OP_EQ  = 4'b1010, OP_NE  = 4'b1011, OP_SRA = 4'b1110;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       aluop;
    logic [RA_W-1:0]  dest;
    logic             we;
    logic             illegal;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  logic [5:0]  op, funct;
  logic [4:0]  rt_idx, rd_idx, shamt;
  logic [15:0] imm;
  logic        unused_ok;

  assign op        = in_instr[31:26];
  assign rt_idx    = in_instr[20:16];
  assign rd_idx    = in_instr[15:11];
  assign shamt     = in_instr[10:6];
  assign funct     = in_instr[5:0];
  assign imm       = in_instr[15:0];
  assign unused_ok = ^in_instr[25:21];

  entry_t dec;

  always_comb begin
    dec         = '0;
    dec.a       = in_rs_data;
    dec.b       = {{(WIDTH-16){imm[15]}}, imm};
    dec.dest    = RA_W'(rt_idx);
    dec.we      = 1'b1;
    dec.aluop   = OP_ADD;
    case (op)
      6'h00: begin
        dec.dest = RA_W'(rd_idx);
        dec.b    = in_rt_data;
        case (funct)
          6'h20, 6'h21: dec.aluop = OP_ADD;
          6'h22, 6'h23: dec.aluop = OP_SUB;
          6'h24:        dec.aluop = OP_AND;
          6'h25:        dec.aluop = OP_OR;
          6'h26:        dec.aluop = OP_XOR;
          6'h27:        dec.aluop = OP_NOR;
          6'h2A, 6'h2B: dec.aluop = OP_LT;
          6'h00, 6'h02, 6'h03: begin
            dec.a     = in_rt_data;
            dec.b     = {{(WIDTH-5){1'b0}}, shamt};
            dec.aluop = (funct == 6'h00) ? OP_SLL : (funct == 6'h02) ? OP_SRL : OP_SRA;
          end
          6'h04, 6'h06, 6'h07: begin
            dec.a     = in_rt_data;
            dec.b     = in_rs_data;
            dec.aluop = (funct == 6'h04) ? OP_SLL : (funct == 6'h06) ? OP_SRL : OP_SRA;
          end
          default: dec.illegal = 1'b1;
        endcase
      end
      6'h08, 6'h09, 6'h23: dec.aluop = OP_ADD;
      6'h0A:               dec.aluop = OP_LT;
      6'h0C: begin dec.aluop = OP_AND; dec.b = {{(WIDTH-16){1'b0}}, imm}; end
      6'h0D: begin dec.aluop = OP_OR;  dec.b = {{(WIDTH-16){1'b0}}, imm}; end
      6'h0E: begin dec.aluop = OP_XOR; dec.b = {{(WIDTH-16){1'b0}}, imm}; end
      6'h0F: begin
        dec.aluop = OP_SLL;
        dec.a     = {{(WIDTH-16){1'b0}}, imm};
        dec.b     = WIDTH'(16);
      end
      6'h2B: dec.we = 1'b0;
      6'h04, 6'h05: begin
        dec.aluop = (op == 6'h04) ? OP_EQ : OP_NE;
        dec.b     = in_rt_data;
        dec.we    = 1'b0;
      end
      default: dec.illegal = 1'b1;
    endcase
    // Unsupported encodings still flow down the pipe, but as an inert entry.
    if (dec.illegal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
    if (dec.dest == '0) dec.we = 1'b0;
  end

  state_t state, state_nxt;
  entry_t main_q, skid_q, main_nxt;
  logic   in_ready_q;
  logic   load_main, load_skid;
  logic   in_hs, out_hs;

  assign in_ready  = in_ready_q & ~rst;
  assign out_valid = ~rst & (state != EMPTY);
  assign in_hs     = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready;

  always_comb begin
    state_nxt = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    main_nxt  = dec;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (in_hs) begin state_nxt = ONE; load_main = 1'b1; end
        ONE: begin
          if (in_hs && !out_hs) begin
            state_nxt = TWO;
            load_skid = 1'b1;
          end else if (in_hs && out_hs) begin
            load_main = 1'b1;
          end else if (out_hs) begin
            state_nxt = EMPTY;
          end
        end
        TWO: if (out_hs) begin
          state_nxt = ONE;
          load_main = 1'b1;
          main_nxt  = skid_q;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      in_ready_q <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != TWO);
      if (load_main) main_q <= main_nxt;
      if (load_skid) skid_q <= dec;
    end
  end

  entry_t shown;
  assign shown       = out_valid ? main_q : '0;
  assign out_a       = shown.a;
  assign out_b       = shown.b;
  assign out_aluop   = shown.aluop;
  assign out_dest    = shown.dest;
  assign out_we      = shown.we;
  assign out_illegal = shown.illegal;

endmodule
